// File: rtl/vga_sprite_renderer_pkg.sv
// Shared types, colour constants and sprite bitmaps for the VGA sprite renderer.
// The bitmaps are defined as a function of (entity, lx, ly) so the ROM needs no init file.
package vga_sprite_renderer_pkg;

    typedef enum logic [1:0] {
        MODE_GAME  = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_SOLID = 2'd3
    } mode_e;

    localparam int          ENT_NOTHING  = 0;
    localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
    localparam logic [15:0] RGB565_BLACK = 16'h0000;
    localparam logic [15:0] RGB565_ERR   = 16'hF81F;

    typedef struct packed {
        logic        valid;
        mode_e       mode;
        logic        ent_none;
        logic        ent_err;
        logic        blink;
        logic        parity;
        logic [2:0]  bar_rgb;
        logic [15:0] bg;
    } s1_t;

    function automatic logic [15:0] expand_k1(input logic [2:0] c);
        return {{5{c[2]}}, {6{c[1]}}, {5{c[0]}}};
    endfunction

    function automatic logic [15:0] expand_k2(input logic [5:0] c);
        return {c[5:4], c[5:4], c[5], c[3:2], c[3:2], c[3:2], c[1:0], c[1:0], c[1]};
    endfunction

    // Bitmaps cycle every three entities: framed yellow block, blue tile with white diagonal, XOR texture.
    function automatic logic [2:0] sprite_rgb3(input int ent_idx, input int lx, input int ly,
                                               input int w, input int h);
        logic [2:0] c;
        case (ent_idx % 3)
            0:       c = (lx == 0 || lx == w - 1 || ly == 0 || ly == h - 1) ? 3'b000 : 3'b110;
            1:       c = (lx == ly) ? 3'b111 : 3'b001;
            default: c = 3'(lx ^ ly);
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_sprite_renderer_if.sv
// Pixel request/response bundle between vga_ctrl (master) and the sprite renderer (slave).
interface vga_sprite_renderer_if #(
    parameter int ENT_W = 2
);
    logic [9:0]       iPix_x;
    logic [9:0]       iPix_y;
    logic             iPix_valid;
    logic [ENT_W-1:0] iEnt;
    logic [15:0]      oPix_data;
    logic             oPix_valid;

    modport master (
        output iPix_x, iPix_y, iPix_valid, iEnt,
        input  oPix_data, oPix_valid
    );

    modport slave (
        input  iPix_x, iPix_y, iPix_valid, iEnt,
        output oPix_data, oPix_valid
    );
endinterface

// File: rtl/vga_sprite_rom.sv
// Sprite bitmap ROM: one BPP-bit colour code per (entity, lx, ly), registered read.
module vga_sprite_rom
    import vga_sprite_renderer_pkg::*;
#(
    parameter int N_ENT = 3,
    parameter int SQ_W  = 16,
    parameter int SQ_H  = 16,
    parameter int BPP   = 3,
    localparam int EIDX_W = (N_ENT > 1) ? $clog2(N_ENT) : 1,
    localparam int LX_W   = $clog2(SQ_W),
    localparam int LY_W   = $clog2(SQ_H)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [EIDX_W-1:0] ent_idx,
    input  logic [LX_W-1:0]   lx,
    input  logic [LY_W-1:0]   ly,
    output logic [BPP-1:0]    code
);
    logic [2:0]     rgb3;
    logic [BPP-1:0] code_d, code_q;

    always_comb begin
        rgb3 = sprite_rgb3(int'(ent_idx), int'(lx), int'(ly), SQ_W, SQ_H);
        if (BPP == 6) begin
            code_d = BPP'({rgb3[2], rgb3[2], rgb3[1], rgb3[1], rgb3[0], rgb3[0]});
        end else begin
            code_d = BPP'(rgb3);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q <= '0;
        end else begin
            code_q <= code_d;
        end
    end

    assign code = code_q;
endmodule

// File: rtl/vga_sprite_renderer.sv
// Two-stage pixel renderer feeding vga_ctrl: sprite game view, colour bars, checkerboard or solid fill.
// Mode and frame count switch only on the frame-start pixel, which already renders with the new values.
module vga_sprite_renderer
    import vga_sprite_renderer_pkg::*;
#(
    parameter int N_ENT       = 3,
    parameter int ENT_W       = 2,
    parameter int SQ_W        = 16,
    parameter int SQ_H        = 16,
    parameter int BPP         = 3,
    parameter int H_ACTIVE    = 640,
    parameter int BLINK_SHIFT = 4
) (
    input  logic                        iVGA_CLK,
    input  logic                        sys_reset_n,
    vga_sprite_renderer_if.slave        pix,
    input  logic [1:0]                  iMode,
    input  logic [15:0]                 iBg_color,
    input  logic [N_ENT-1:0]            iBlink_mask,
    output logic [7:0]                  oFrame_cnt
);
    localparam int EIDX_W = (N_ENT > 1) ? $clog2(N_ENT) : 1;
    localparam int LX_W   = $clog2(SQ_W);
    localparam int LY_W   = $clog2(SQ_H);
    localparam int BAR_W  = H_ACTIVE / 8;
    localparam logic [ENT_W-1:0] ENT_MAX = ENT_W'(N_ENT);

    mode_e             mode_q, mode_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    s1_t               s1_q, s1_d;
    logic [15:0]       pix_data_q, pix_data_d;
    logic              pix_valid_q, pix_valid_d;
    logic              frame_start;
    logic              ent_ok;
    logic [EIDX_W-1:0] ent_idx;
    logic [BPP-1:0]    code;
    logic [15:0]       sprite_px;

    always_comb begin
        frame_start = pix.iPix_valid && (pix.iPix_x == '0) && (pix.iPix_y == '0);
        mode_d      = frame_start ? mode_e'(iMode) : mode_q;
        frame_cnt_d = frame_start ? frame_cnt_q + 8'd1 : frame_cnt_q;
        ent_ok      = (pix.iEnt != ENT_W'(ENT_NOTHING)) && (pix.iEnt <= ENT_MAX);
        ent_idx     = ent_ok ? EIDX_W'(pix.iEnt - 1'b1) : '0;

        s1_d.valid    = pix.iPix_valid;
        s1_d.mode     = mode_d;
        s1_d.ent_none = (pix.iEnt == ENT_W'(ENT_NOTHING));
        s1_d.ent_err  = !ent_ok && !s1_d.ent_none;
        // Blink follows the count of the frame being drawn, including its first pixel.
        s1_d.blink    = ent_ok && iBlink_mask[ent_idx] && frame_cnt_d[BLINK_SHIFT];
        s1_d.parity   = pix.iPix_x[LX_W] ^ pix.iPix_y[LY_W];
        s1_d.bar_rgb  = (pix.iPix_x >= 10'(H_ACTIVE)) ? 3'd0
                                                       : 3'd7 - 3'(pix.iPix_x / 10'(BAR_W));
        s1_d.bg       = iBg_color;
    end

    vga_sprite_rom #(
        .N_ENT (N_ENT),
        .SQ_W  (SQ_W),
        .SQ_H  (SQ_H),
        .BPP   (BPP)
    ) u_rom (
        .clk     (iVGA_CLK),
        .rst_n   (sys_reset_n),
        .ent_idx (ent_idx),
        .lx      (pix.iPix_x[LX_W-1:0]),
        .ly      (pix.iPix_y[LY_W-1:0]),
        .code    (code)
    );

    always_comb begin
        if (BPP == 6) begin
            sprite_px = expand_k2(6'(code));
        end else begin
            sprite_px = expand_k1(3'(code));
        end
        pix_valid_d = s1_q.valid;
        pix_data_d  = RGB565_BLACK;
        if (s1_q.valid) begin
            case (s1_q.mode)
                MODE_GAME: begin
                    if (s1_q.ent_err) begin
                        pix_data_d = RGB565_ERR;
                    end else if (s1_q.ent_none || s1_q.blink || code == '0) begin
                        pix_data_d = s1_q.bg;
                    end else begin
                        pix_data_d = sprite_px;
                    end
                end
                MODE_BARS:  pix_data_d = expand_k1(s1_q.bar_rgb);
                MODE_CHECK: pix_data_d = s1_q.parity ? RGB565_BLACK : RGB565_WHITE;
                MODE_SOLID: pix_data_d = s1_q.bg;
                default:    pix_data_d = RGB565_BLACK;
            endcase
        end
    end

    always_ff @(posedge iVGA_CLK or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            mode_q      <= MODE_GAME;
            frame_cnt_q <= '0;
            s1_q        <= '0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            frame_cnt_q <= frame_cnt_d;
            s1_q        <= s1_d;
            pix_data_q  <= pix_data_d;
            pix_valid_q <= pix_valid_d;
        end
    end

    assign pix.oPix_data  = pix_data_q;
    assign pix.oPix_valid = pix_valid_q;
    assign oFrame_cnt     = frame_cnt_q;
endmodule
